// File: rtl/tlb_port_arbiter_pkg.sv
// Shared definitions for the TLB search-port arbiter: default widths,
// maintenance op-code constants and the maintenance FSM state encoding.
// Imported by tlb_port_arbiter and tlb_lookup_mux.
package tlb_port_arbiter_pkg;

    localparam int VPN2_W = 19;
    localparam int ASID_W = 8;
    localparam int IDX_W  = 4;
    localparam int PFN_W  = 20;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EXEC  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/tlb_lookup_mux.sv
// Grant logic and TLB search-key mux for the shared TLB search port.
// Ports: arb_en/idle qualifiers from the FSM, per-requester req/key, probe
// key (cp0_hi_vpn2 + cp0_asid), combinational grants and the s_* search key.
// Optional feature macro: TLB_ARB_STARVE_GUARD_EN (instruction-side starvation
// counter); without it data always beats instruction.
module tlb_lookup_mux #(
    parameter int VPN2_W     = tlb_port_arbiter_pkg::VPN2_W,
    parameter int ASID_W     = tlb_port_arbiter_pkg::ASID_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_en,
    input  logic              idle,
    input  logic              probe_en,
    input  logic              inst_req,
    input  logic              data_req,
    input  logic [VPN2_W-1:0] inst_vpn2,
    input  logic              inst_odd,
    input  logic [VPN2_W-1:0] data_vpn2,
    input  logic              data_odd,
    input  logic [ASID_W-1:0] cp0_asid,
    input  logic [VPN2_W-1:0] cp0_hi_vpn2,
    output logic              inst_grant,
    output logic              data_grant,
    output logic [VPN2_W-1:0] s_vpn2,
    output logic              s_odd,
    output logic [ASID_W-1:0] s_asid
);

    logic inst_win;

`ifdef TLB_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    assign inst_win = (starve_cnt == CNT_W'(STARVE_MAX));

    // Counts instruction-side denials while IDLE (maintenance denials included);
    // saturates so a long maintenance stall cannot wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (inst_grant) begin
            starve_cnt <= '0;
        end else if (idle && inst_req && !inst_win) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst, idle, STARVE_MAX[0]};
    assign inst_win  = 1'b0;
`endif

    always_comb begin
        data_grant = arb_en && data_req && !(inst_win && inst_req);
        inst_grant = arb_en && inst_req && !data_grant;
    end

    always_comb begin
        s_vpn2 = '0;
        s_odd  = 1'b0;
        s_asid = '0;
        if (data_grant) begin
            s_vpn2 = data_vpn2;
            s_odd  = data_odd;
            s_asid = cp0_asid;
        end else if (inst_grant) begin
            s_vpn2 = inst_vpn2;
            s_odd  = inst_odd;
            s_asid = cp0_asid;
        end else if (probe_en) begin
            // TLBP always probes with the even page of EntryHi's pair
            s_vpn2 = cp0_hi_vpn2;
            s_odd  = 1'b0;
            s_asid = cp0_asid;
        end
    end

endmodule

// File: rtl/tlb_port_arbiter.sv
// Shares the TLB search port between IMMU and DMMU and sequences TLBP/TLBR/
// TLBWI/TLBWR (IDLE->DRAIN->EXEC->DONE) so they never overlap a lookup.
// Ports: per-requester req/key/grant/rsp_valid, shared registered rsp_*,
// maintenance op handshake + CP0 strobes, TLB search key/result and strobes.
// Optional feature macro: TLB_ARB_STARVE_GUARD_EN (see tlb_lookup_mux).
module tlb_port_arbiter #(
    parameter int VPN2_W     = tlb_port_arbiter_pkg::VPN2_W,
    parameter int ASID_W     = tlb_port_arbiter_pkg::ASID_W,
    parameter int IDX_W      = tlb_port_arbiter_pkg::IDX_W,
    parameter int PFN_W      = tlb_port_arbiter_pkg::PFN_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              data_req,
    input  logic [VPN2_W-1:0] inst_vpn2,
    input  logic [VPN2_W-1:0] data_vpn2,
    input  logic              inst_odd,
    input  logic              data_odd,
    output logic              inst_grant,
    output logic              data_grant,
    output logic              inst_rsp_valid,
    output logic              data_rsp_valid,
    output logic              rsp_hit,
    output logic [IDX_W-1:0]  rsp_index,
    output logic [PFN_W-1:0]  rsp_pfn,
    output logic [2:0]        rsp_c,
    output logic              rsp_d,
    output logic              rsp_v,
    input  logic [ASID_W-1:0] cp0_asid,
    input  logic [VPN2_W-1:0] cp0_hi_vpn2,
    input  logic              op_valid,
    input  logic [1:0]        op_code,
    output logic              op_ready,
    output logic              op_done,
    output logic              tlbp_write,
    output logic              tlbr_write,
    output logic [IDX_W:0]    tlbp_index,
    output logic [VPN2_W-1:0] tlb_s_vpn2,
    output logic              tlb_s_odd,
    output logic [ASID_W-1:0] tlb_s_asid,
    input  logic              tlb_s_hit,
    input  logic [IDX_W-1:0]  tlb_s_index,
    input  logic [PFN_W-1:0]  tlb_s_pfn,
    input  logic [2:0]        tlb_s_c,
    input  logic              tlb_s_d,
    input  logic              tlb_s_v,
    output logic              tlb_w_en,
    output logic              tlb_w_random,
    output logic              tlb_r_en
);

    import tlb_port_arbiter_pkg::*;

    arb_state_t state, state_nxt;
    logic [1:0] op_q;
    logic       arb_en;
    logic       probe_en;

    // Grants and op_ready are combinational, so they are explicitly held low
    // while reset is asserted rather than relying on the state register alone.
    assign arb_en   = (state == ST_IDLE) && !op_valid && !rst;
    assign op_ready = (state == ST_IDLE) && op_valid && !rst;
    assign probe_en = (state == ST_EXEC) && (op_q == OP_TLBP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            op_q  <= OP_TLBP;
        end else begin
            state <= state_nxt;
            if (op_ready) begin
                op_q <= op_code;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        tlb_w_en     = 1'b0;
        tlb_w_random = 1'b0;
        tlb_r_en     = 1'b0;
        op_done      = 1'b0;
        tlbp_write   = 1'b0;
        tlbr_write   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                tlb_w_en     = (op_q == OP_TLBWI) || (op_q == OP_TLBWR);
                tlb_w_random = (op_q == OP_TLBWR);
                tlb_r_en     = (op_q == OP_TLBR);
                state_nxt    = ST_DONE;
            end
            ST_DONE: begin
                op_done    = 1'b1;
                tlbp_write = (op_q == OP_TLBP);
                tlbr_write = (op_q == OP_TLBR);
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    tlb_lookup_mux #(
        .VPN2_W     (VPN2_W),
        .ASID_W     (ASID_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_lookup_mux (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (arb_en),
        .idle        (state == ST_IDLE),
        .probe_en    (probe_en),
        .inst_req    (inst_req),
        .data_req    (data_req),
        .inst_vpn2   (inst_vpn2),
        .inst_odd    (inst_odd),
        .data_vpn2   (data_vpn2),
        .data_odd    (data_odd),
        .cp0_asid    (cp0_asid),
        .cp0_hi_vpn2 (cp0_hi_vpn2),
        .inst_grant  (inst_grant),
        .data_grant  (data_grant),
        .s_vpn2      (tlb_s_vpn2),
        .s_odd       (tlb_s_odd),
        .s_asid      (tlb_s_asid)
    );

    // Response fields only load on a grant; the per-requester valid bits
    // tell each MMU whether the shared fields belong to it this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_rsp_valid <= 1'b0;
            data_rsp_valid <= 1'b0;
            rsp_hit        <= 1'b0;
            rsp_index      <= '0;
            rsp_pfn        <= '0;
            rsp_c          <= '0;
            rsp_d          <= 1'b0;
            rsp_v          <= 1'b0;
            tlbp_index     <= '0;
        end else begin
            inst_rsp_valid <= inst_grant;
            data_rsp_valid <= data_grant;
            if (inst_grant || data_grant) begin
                rsp_hit   <= tlb_s_hit;
                rsp_index <= tlb_s_index;
                rsp_pfn   <= tlb_s_pfn;
                rsp_c     <= tlb_s_c;
                rsp_d     <= tlb_s_d;
                rsp_v     <= tlb_s_v;
            end
            if (probe_en) begin
                tlbp_index <= {!tlb_s_hit, tlb_s_index};
            end
        end
    end

endmodule

// File: tb/tb_tlb_port_arbiter.sv
module tb_tlb_port_arbiter;
    import tlb_port_arbiter_pkg::*;

    localparam int SM = 3;
`ifdef TLB_ARB_STARVE_GUARD_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, data_req, inst_odd, data_odd;
    logic [18:0] inst_vpn2, data_vpn2, cp0_hi_vpn2;
    logic [7:0]  cp0_asid;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        inst_grant, data_grant, inst_rsp_valid, data_rsp_valid;
    logic        rsp_hit, rsp_d, rsp_v;
    logic [3:0]  rsp_index;
    logic [19:0] rsp_pfn;
    logic [2:0]  rsp_c;
    logic        op_ready, op_done, tlbp_write, tlbr_write;
    logic [4:0]  tlbp_index;
    logic [18:0] tlb_s_vpn2;
    logic        tlb_s_odd;
    logic [7:0]  tlb_s_asid;
    logic        tlb_s_hit, tlb_s_d, tlb_s_v;
    logic [3:0]  tlb_s_index;
    logic [19:0] tlb_s_pfn;
    logic [2:0]  tlb_s_c;
    logic        tlb_w_en, tlb_w_random, tlb_r_en;

    always #5 clk = ~clk;

    tlb_port_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .data_req(data_req),
        .inst_vpn2(inst_vpn2), .data_vpn2(data_vpn2),
        .inst_odd(inst_odd), .data_odd(data_odd),
        .inst_grant(inst_grant), .data_grant(data_grant),
        .inst_rsp_valid(inst_rsp_valid), .data_rsp_valid(data_rsp_valid),
        .rsp_hit(rsp_hit), .rsp_index(rsp_index), .rsp_pfn(rsp_pfn),
        .rsp_c(rsp_c), .rsp_d(rsp_d), .rsp_v(rsp_v),
        .cp0_asid(cp0_asid), .cp0_hi_vpn2(cp0_hi_vpn2),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
        .op_done(op_done), .tlbp_write(tlbp_write), .tlbr_write(tlbr_write),
        .tlbp_index(tlbp_index),
        .tlb_s_vpn2(tlb_s_vpn2), .tlb_s_odd(tlb_s_odd), .tlb_s_asid(tlb_s_asid),
        .tlb_s_hit(tlb_s_hit), .tlb_s_index(tlb_s_index), .tlb_s_pfn(tlb_s_pfn),
        .tlb_s_c(tlb_s_c), .tlb_s_d(tlb_s_d), .tlb_s_v(tlb_s_v),
        .tlb_w_en(tlb_w_en), .tlb_w_random(tlb_w_random), .tlb_r_en(tlb_r_en)
    );

    // TLB stand-in: result = {hit, index[4], pfn[20], c[3], d, v} (30 bits),
    // either a fixed override or a hash of the search key.
    logic        ovr, ovr_hit;
    logic [3:0]  ovr_idx;
    logic [19:0] ovr_pfn;

    function automatic logic [29:0] tlb_hash(input logic [18:0] v, input logic o, input logic [7:0] a);
        logic [19:0] p;
        p = {v, o} ^ {a, 12'h000};
        return {^{v, o, a}, v[3:0] ^ a[3:0], p, v[6:4], v[7], v[8] ^ o};
    endfunction

    function automatic logic [29:0] tlb_model(input logic [18:0] v, input logic o, input logic [7:0] a);
        if (ovr) return {ovr_hit, ovr_idx, ovr_pfn, 3'd3, 1'b1, 1'b1};
        return tlb_hash(v, o, a);
    endfunction

    logic [29:0] tlb_res;
    assign tlb_res = ovr ? {ovr_hit, ovr_idx, ovr_pfn, 5'b01111} : tlb_hash(tlb_s_vpn2, tlb_s_odd, tlb_s_asid);
    assign {tlb_s_hit, tlb_s_index, tlb_s_pfn, tlb_s_c, tlb_s_d, tlb_s_v} = tlb_res;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: op_age = cycles since the op was accepted (-1: idle).
    int          op_age, scnt;
    logic [1:0]  mop;
    logic        exp_ivld, exp_dvld;
    logic [29:0] exp_res;
    logic [4:0]  exp_pidx;
    // Observations and model grants of the most recent cycle
    logic        og_i, og_d, ordy, odone, otw, orw, owen, owr, oren, mg_i, mg_d, mrdy;
    logic [27:0] okey;

    task automatic model_reset();
        op_age = -1; scnt = 0; mop = 2'b00;
        exp_ivld = 0; exp_dvld = 0; exp_res = '0; exp_pidx = '0;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_vld"}, {28'd0, inst_grant, data_grant, inst_rsp_valid, data_rsp_valid}, 32'd0);
        chk({tag, "_rsp"}, {2'b0, rsp_hit, rsp_index, rsp_pfn, rsp_c, rsp_d, rsp_v}, 32'd0);
        chk({tag, "_ctl"}, {20'd0, op_ready, op_done, tlbp_write, tlbr_write, tlbp_index,
                            tlb_w_en, tlb_w_random, tlb_r_en}, 32'd0);
        chk({tag, "_key"}, {4'd0, tlb_s_vpn2, tlb_s_odd, tlb_s_asid}, 32'd0);
    endtask

    // One clock cycle: inputs are already set; check at the falling edge,
    // then advance the model just after the rising edge.
    task automatic cyc();
        logic        idle, eg_i, eg_d, exec, done;
        logic [27:0] ek;
        logic [29:0] pr;
        @(negedge clk);
        idle = (op_age < 0);
        exec = (op_age == 2);
        done = (op_age == 3);
        eg_i = 0; eg_d = 0;
        if (idle && !op_valid) begin
            if (data_req && !(STARVE_ON && inst_req && scnt >= SM)) eg_d = 1;
            else if (inst_req) eg_i = 1;
        end
        if (eg_d)                      ek = {data_vpn2, data_odd, cp0_asid};
        else if (eg_i)                 ek = {inst_vpn2, inst_odd, cp0_asid};
        else if (exec && mop == OP_TLBP) ek = {cp0_hi_vpn2, 1'b0, cp0_asid};
        else                           ek = '0;

        chk("op_ready", {31'd0, op_ready}, {31'd0, idle && op_valid});
        chk("data_grant", {31'd0, data_grant}, {31'd0, eg_d});
        chk("inst_grant", {31'd0, inst_grant}, {31'd0, eg_i});
        chk("search_key", {4'd0, tlb_s_vpn2, tlb_s_odd, tlb_s_asid}, {4'd0, ek});
        chk("strobes", {26'd0, tlb_w_en, tlb_w_random, tlb_r_en, op_done, tlbp_write, tlbr_write},
            {26'd0, exec && mop[1], exec && mop == OP_TLBWR, exec && mop == OP_TLBR,
             done, done && mop == OP_TLBP, done && mop == OP_TLBR});
        chk("rsp_valid", {30'd0, inst_rsp_valid, data_rsp_valid}, {30'd0, exp_ivld, exp_dvld});
        if (exp_ivld || exp_dvld)
            chk("rsp_fields", {2'b0, rsp_hit, rsp_index, rsp_pfn, rsp_c, rsp_d, rsp_v}, {2'b0, exp_res});
        chk("tlbp_index", {27'd0, tlbp_index}, {27'd0, exp_pidx});

        og_i = inst_grant; og_d = data_grant; ordy = op_ready; odone = op_done;
        otw = tlbp_write; orw = tlbr_write; owen = tlb_w_en; owr = tlb_w_random; oren = tlb_r_en;
        okey = {tlb_s_vpn2, tlb_s_odd, tlb_s_asid};
        mg_i = eg_i; mg_d = eg_d; mrdy = idle && op_valid;
        pr = tlb_model(cp0_hi_vpn2, 1'b0, cp0_asid);

        @(posedge clk);
        #1;
        exp_ivld = eg_i;
        exp_dvld = eg_d;
        if (eg_i || eg_d) exp_res = tlb_model(ek[27:9], ek[8], ek[7:0]);
        if (exec && mop == OP_TLBP) exp_pidx = {~pr[29], pr[28:25]};
        if (STARVE_ON) begin
            if (eg_i) scnt = 0;
            else if (idle && inst_req) scnt++;
        end
        if (idle) begin
            if (op_valid) begin op_age = 1; mop = op_code; end
        end else if (op_age == 3) op_age = -1;
        else op_age++;
    endtask

    initial begin
        logic [6:0] ig_seen;
        rst = 1; ovr = 0; ovr_hit = 0; ovr_idx = 0; ovr_pfn = 0;
        inst_req = 0; data_req = 0; inst_odd = 0; data_odd = 0;
        inst_vpn2 = 0; data_vpn2 = 0; cp0_hi_vpn2 = 0; cp0_asid = 8'h3C;
        op_valid = 0; op_code = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // requests presented during reset must not be granted
        inst_req = 1; data_req = 1; op_valid = 1;
        #1;
        rst_chk("reset");
        inst_req = 0; data_req = 0; op_valid = 0;
        #1 rst = 0;

        // Starvation: both requesters held for 7 cycles
        inst_req = 1; data_req = 1; inst_vpn2 = 19'h00111; data_vpn2 = 19'h00222;
        for (int i = 0; i < 7; i++) begin
            cyc();
            ig_seen[i] = og_i;
        end
        chk("starve_pattern", {25'd0, ig_seen}, STARVE_ON ? 32'h08 : 32'h00);
        data_req = 0;
        cyc();                                   // inst alone: granted, counter cleared
        chk("inst_alone_grant", {31'd0, og_i}, 32'd1);
        inst_req = 0;

        // Data beats instruction; registered response one cycle later
        ovr = 1; ovr_hit = 1; ovr_idx = 4'd5; ovr_pfn = 20'h00ABC;
        data_req = 1; data_vpn2 = 19'h12345; data_odd = 1; inst_req = 1; inst_vpn2 = 19'h00777;
        cyc();
        chk("t1_grants", {30'd0, og_d, og_i}, 32'b10);
        data_req = 0;
        chk("t1_rsp", {7'd0, data_rsp_valid, rsp_index, rsp_pfn}, {7'd0, 1'b1, 4'd5, 20'h00ABC});
        cyc();                                   // inst now granted
        inst_req = 0;
        cyc();

        // TLBP miss
        ovr_hit = 0; ovr_idx = 4'd9; cp0_hi_vpn2 = 19'h00040;
        op_valid = 1; op_code = OP_TLBP;
        cyc();
        chk("tlbp_ready", {31'd0, ordy}, 32'd1);
        op_valid = 0;
        cyc();
        cyc();
        chk("tlbp_key", {4'd0, okey}, {4'd0, 19'h00040, 1'b0, cp0_asid});
        cyc();
        chk("tlbp_done", {30'd0, odone, otw}, 32'b11);
        chk("tlbp_P", {31'd0, tlbp_index[4]}, 32'd1);
        ovr = 0;

        // TLBWR while data_req is held
        data_req = 1; data_vpn2 = 19'h0ABCD; op_valid = 1; op_code = OP_TLBWR;
        cyc();
        chk("wr_ready_nogrant", {30'd0, ordy, og_d}, 32'b10);
        op_valid = 0;
        cyc(); chk("wr_n1_nogrant", {31'd0, og_d}, 32'd0);
        cyc(); chk("wr_exec", {29'd0, og_d, owen, owr}, 32'b011);
        cyc(); chk("wr_n3_nogrant", {31'd0, og_d}, 32'd0);
        cyc(); chk("wr_n4_grant", {31'd0, og_d}, 32'd1);
        data_req = 0;

        // TLBR together with inst_req
        inst_req = 1; inst_vpn2 = 19'h05555; op_valid = 1; op_code = OP_TLBR;
        cyc();
        chk("rd_ready_nogrant", {30'd0, ordy, og_i}, 32'b10);
        op_valid = 0;
        cyc();
        cyc(); chk("rd_exec", {31'd0, oren}, 32'd1);
        cyc(); chk("rd_write", {31'd0, orw}, 32'd1);
        cyc(); chk("rd_inst_resume", {31'd0, og_i}, 32'd1);
        inst_req = 0;

        // Reset pulsed during EXEC of a TLBWI
        op_valid = 1; op_code = OP_TLBWI;
        cyc();
        op_valid = 0;
        cyc();                                   // now just after the edge into EXEC
        #2 rst = 1;
        #1;
        rst_chk("mid_rst");
        model_reset();
        scnt = 0;
        #1 rst = 0;
        repeat (4) cyc();                        // model expects no op_done
        op_valid = 1; op_code = OP_TLBWI;
        cyc();
        chk("post_rst_ready", {31'd0, ordy}, 32'd1);
        op_valid = 0;
        cyc(); cyc(); cyc();
        chk("post_rst_done", {31'd0, odone}, 32'd1);

        // Randomized traffic against the model, honouring the hold-until-grant rule
        for (int n = 0; n < 3000; n++) begin
            if (!data_req || mg_d) begin
                data_req = ($urandom_range(0, 3) != 0);
                data_vpn2 = 19'($urandom); data_odd = 1'($urandom);
            end
            if (!inst_req || mg_i) begin
                inst_req = ($urandom_range(0, 2) != 0);
                inst_vpn2 = 19'($urandom); inst_odd = 1'($urandom);
            end
            if (!op_valid || mrdy) begin
                op_valid = ($urandom_range(0, 9) == 0);
                op_code = 2'($urandom);
            end
            if ($urandom_range(0, 7) == 0) cp0_asid = 8'($urandom);
            if ($urandom_range(0, 7) == 0) cp0_hi_vpn2 = 19'($urandom);
            mg_i = 0; mg_d = 0; mrdy = 0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
